// File: rtl/sample_ram_pkg.sv
// Shared types and sizing for the sample RAM sequencer.
// Parity is built in when SAMPLE_RAM_PARITY_EN is defined.
package sample_ram_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_POST     = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_RD_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    ARMED    = S_ARMED,
    POST     = S_POST,
    RD_ISSUE = S_RD_ISSUE,
    RD_WAIT  = S_RD_WAIT,
    RD_HOLD  = S_RD_HOLD,
    DONE     = S_DONE
  } state_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sample_ram_ptr.sv
// Modulo-DEPTH address pointer with clear, load and increment.
// wrap pulses on the increment from DEPTH-1 back to 0.
module sample_ram_ptr
  import sample_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] nxt,
  output logic              wrap
);

  assign nxt  = ptr + ADDR_W'(1);
  assign wrap = inc & (&ptr);

  always_ff @(posedge clock) begin
    if (reset || clr)
      ptr <= '0;
    else if (load)
      ptr <= load_val;
    else if (inc)
      ptr <= nxt;
  end

endmodule

// File: rtl/sample_ram_sequencer.sv
// Pre/post-trigger capture into a single-port RAM, then oldest-first readout.
// Define SAMPLE_RAM_PARITY_EN for write parity and a sticky parity_err output.
module sample_ram_sequencer
  import sample_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] post_count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_dip,
  input  logic [DATA_W-1:0] ram_do,
`ifdef SAMPLE_RAM_PARITY_EN
  input  logic              ram_dop,
  output logic              parity_err
`else
  input  logic              ram_dop
`endif
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CW    = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr, wr_nxt, rd_ptr;
  logic [ADDR_W-1:0] remaining, pc_q;
  logic [CW-1:0]     count, len;
  logic              wrapped, wrapped_n, wr_wrap;
  logic              cap, wr, start, to_rd, acc, rd_iss;
  logic [ADDR_W-1:0] unused_rd_nxt;
  logic              unused_rd_wrap;

  assign cap    = (state == ARMED) || (state == POST);
  assign wr     = cap & sample_valid & ~abort & ~reset;
  assign start  = ((state == IDLE) || (state == DONE)) & arm & ~abort;
  assign rd_iss = (state == RD_ISSUE) & ~reset;
  assign acc    = (state == RD_HOLD) & rd_ready & ~abort;

  // Readout setup must see this cycle's write already applied.
  assign wrapped_n = wrapped | wr_wrap;
  assign len = wrapped_n ? CW'(DEPTH) : {1'b0, wr_nxt};
  assign to_rd = wr &
    (((state == ARMED) & trigger & (pc_q == '0)) |
     ((state == POST) & (remaining == ADDR_W'(1))));

  sample_ram_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clock    (clock),
    .reset    (reset),
    .clr      (start),
    .load     (1'b0),
    .load_val ('0),
    .inc      (wr),
    .ptr      (wr_ptr),
    .nxt      (wr_nxt),
    .wrap     (wr_wrap)
  );

  sample_ram_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clock    (clock),
    .reset    (reset),
    .clr      (1'b0),
    .load     (to_rd),
    .load_val (wrapped_n ? wr_nxt : '0),
    .inc      (acc),
    .ptr      (rd_ptr),
    .nxt      (unused_rd_nxt),
    .wrap     (unused_rd_wrap)
  );

  assign ram_en   = wr | rd_iss;
  assign ram_we   = wr;
  assign ram_di   = sample_data;
  assign ram_addr = cap ? wr_ptr : (rd_iss ? rd_ptr : '0);
  assign busy     = (state != IDLE) && (state != DONE);

`ifdef SAMPLE_RAM_PARITY_EN
  assign ram_dip = wr & (^sample_data);
`else
  logic unused_dop;
  assign unused_dop = ram_dop;
  assign ram_dip    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wrapped   <= 1'b0;
      remaining <= '0;
      count     <= '0;
      pc_q      <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
`ifdef SAMPLE_RAM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        rd_valid <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (arm) begin
            pc_q    <= post_count;
            wrapped <= 1'b0;
            state   <= ARMED;
`ifdef SAMPLE_RAM_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
          ARMED: if (sample_valid) begin
            wrapped <= wrapped_n;
            if (trigger) begin
              if (pc_q == '0) begin
                count <= len;
                state <= RD_ISSUE;
              end else begin
                remaining <= pc_q;
                state     <= POST;
              end
            end
          end
          POST: if (sample_valid) begin
            wrapped   <= wrapped_n;
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              count <= len;
              state <= RD_ISSUE;
            end
          end
          RD_ISSUE: state <= RD_WAIT;
          RD_WAIT: begin
            rd_data  <= ram_do;
            rd_valid <= 1'b1;
            state    <= RD_HOLD;
`ifdef SAMPLE_RAM_PARITY_EN
            if ((^ram_do) != ram_dop)
              parity_err <= 1'b1;
`endif
          end
          RD_HOLD: if (rd_ready) begin
            rd_valid <= 1'b0;
            count    <= count - CW'(1);
            if (count == CW'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= RD_ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_ram_sequencer.sv
// Directed bench for sample_ram_sequencer with a 16-entry RAM model.
// Parity checks are included when SAMPLE_RAM_PARITY_EN is defined.
module tb_sample_ram_sequencer;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset, arm, abort, sample_valid, trigger, rd_ready;
  logic [DW-1:0] sample_data;
  logic [AW-1:0] post_count;
  logic          rd_valid, busy, done, ram_en, ram_we, ram_dip;
  logic [DW-1:0] rd_data, ram_di;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do = '0;
  logic          ram_dop = 1'b0;
`ifdef SAMPLE_RAM_PARITY_EN
  logic          parity_err;
`endif

  logic [DW-1:0] mem  [16];
  logic          memp [16];
  logic          flip_en = 1'b0;
  logic [AW-1:0] flip_addr = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sample_ram_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trigger      (trigger),
    .post_count   (post_count),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_di       (ram_di),
    .ram_dip      (ram_dip),
    .ram_do       (ram_do),
`ifdef SAMPLE_RAM_PARITY_EN
    .ram_dop      (ram_dop),
    .parity_err   (parity_err)
`else
    .ram_dop      (ram_dop)
`endif
  );

  // Single-port RAM, registered read
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]  <= ram_di;
        memp[ram_addr] <= ram_dip;
      end else begin
        ram_do  <= mem[ram_addr];
        ram_dop <= memp[ram_addr] ^ (flip_en && ram_addr == flip_addr);
      end
    end
  end

  typedef struct {
    logic [AW-1:0] post;
    int            n;
    int            trig;
    logic [DW-1:0] base;
    int            len;
    int            first;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_arm(input logic [AW-1:0] p);
    arm = 1'b1;
    post_count = p;
    tick();
    arm = 1'b0;
    chk("busy after arm", busy, 1);
  endtask

  task automatic run_capture(input vec_t v);
    do_arm(v.post);
    for (int i = 0; i < v.n; i++) begin
      sample_valid = 1'b0;
      trigger = 1'b1;
      #1 chk("no write without valid", ram_en, 0);
      tick();
      sample_valid = 1'b1;
      sample_data = v.base + DW'(i);
      trigger = (i == v.trig);
      #1;
      chk("write enable", {ram_en, ram_we}, 2'b11);
      chk("write addr", ram_addr, 32'(i % 16));
      tick();
    end
    sample_valid = 1'b0;
    trigger = 1'b0;
    #1;
    chk("rd issue en/we", {ram_en, ram_we}, 2'b10);
    chk("rd issue addr", ram_addr, 32'(v.first % 16));
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int c = 0; c < 16; c++) begin
      if (rd_valid === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("rd_valid timeout", ok, 1);
  endtask

  task automatic readout(input logic [DW-1:0] first_val, input int len);
    rd_ready = 1'b1;
    for (int k = 0; k < len; k++) begin
      wait_valid();
      chk("rd_data", rd_data, 32'(first_val + DW'(k)));
      tick();
      chk("done pulse", done, (k == len - 1));
    end
    rd_ready = 1'b0;
    chk("idle after readout", {busy, rd_valid}, 0);
    tick();
    chk("done single cycle", done, 0);
  endtask

  initial begin
    automatic vec_t tbl[5];
    automatic vec_t one5a = '{post: 0, n: 1, trig: 0, base: 8'h5A, len: 1, first: 0};
    automatic vec_t one77 = '{post: 0, n: 1, trig: 0, base: 8'h77, len: 1, first: 0};
    tbl[0] = '{post: 3,  n: 5,  trig: 1,  base: 8'h10, len: 5,  first: 0};
    tbl[1] = '{post: 2,  n: 20, trig: 17, base: 8'h00, len: 16, first: 4};
    tbl[2] = '{post: 0,  n: 1,  trig: 0,  base: 8'hAA, len: 1,  first: 0};
    tbl[3] = '{post: 0,  n: 16, trig: 15, base: 8'h20, len: 16, first: 0};
    tbl[4] = '{post: 15, n: 16, trig: 0,  base: 8'h40, len: 16, first: 0};

    reset = 1'b1; arm = 0; abort = 0; sample_valid = 0;
    trigger = 0; rd_ready = 0; sample_data = '0; post_count = '0;
    tick(); tick();
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset busy/done", {busy, done}, 0);
    chk("reset ram_en/we", {ram_en, ram_we}, 0);
    chk("reset ram_addr", ram_addr, 0);
    reset = 1'b0;
    tick();

    for (int r = 0; r < 5; r++) begin
      run_capture(tbl[r]);
      readout(tbl[r].base + DW'(tbl[r].first), tbl[r].len);
`ifdef SAMPLE_RAM_PARITY_EN
      chk("parity clean", parity_err, 0);
`endif
    end

    // Backpressure holds the word and issues no reads
    run_capture(one5a);
    rd_ready = 1'b0;
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      chk("bp rd_valid", rd_valid, 1);
      chk("bp rd_data", rd_data, 8'h5A);
      chk("bp ram_en", ram_en, 0);
      tick();
    end
    readout(8'h5A, 1);

    // Abort in POST, write suppressed
    do_arm(4'd5);
    sample_valid = 1'b1; sample_data = 8'h01; trigger = 1'b1;
    tick();
    sample_data = 8'h02; trigger = 1'b0;
    tick();
    sample_data = 8'h03; abort = 1'b1;
    #1 chk("abort write suppressed", ram_en, 0);
    tick();
    abort = 1'b0; sample_valid = 1'b0;
    chk("abort post idle", {busy, rd_valid, done}, 0);
    run_capture(tbl[0]);
    readout(8'h10, 5);

    // Abort in RD_HOLD
    run_capture(one77);
    wait_valid();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort hold idle", {busy, rd_valid, done}, 0);
    tick();
    chk("abort hold no done", done, 0);
    run_capture(tbl[2]);
    readout(8'hAA, 1);

`ifdef SAMPLE_RAM_PARITY_EN
    begin
      automatic vec_t pv = '{post: 0, n: 4, trig: 3, base: 8'h30, len: 4, first: 0};
      flip_en = 1'b1;
      flip_addr = 4'd2;
      run_capture(pv);
      readout(8'h30, 4);
      flip_en = 1'b0;
      chk("parity_err set", parity_err, 1);
      tick();
      chk("parity_err sticky", parity_err, 1);
      do_arm(4'd0);
      chk("parity_err cleared", parity_err, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
